modulation_timer: RTL and testbench

MODULATION_TIMER -- requirements
Module: modulation_timer

---
 rtl/modulation_timer.sv | 116 +++++++++++
 tb/tb_modulation_timer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/modulation_timer.sv
// modulation_timer: two-stage pipelined (SYS_TIME / FREQ_DIV) mod (CYCLE + 1) sample index per segment.
// Segment 1 is built only when MODULATION_TIMER_SEGMENT1_EN is defined; otherwise IDX_1 is tied to 0.
module modulation_timer_div #(
   parameter int LAT     = 66,
   parameter int SW      = 1,
   parameter int OW      = 64,
   parameter bit REM_OUT = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [63:0]   i_n,
   input  logic [15:0]   i_d,
   input  logic [SW-1:0] i_s,
   output logic [OW-1:0] o_res,
   output logic [SW-1:0] o_s
);
   logic [63:0]   w_n [LAT+1];
   logic [15:0]   w_r [LAT+1];
   logic [15:0]   w_d [LAT+1];
   logic [SW-1:0] w_s [LAT+1];
   assign w_n[0] = i_n;
   assign w_r[0] = '0;
   assign w_d[0] = i_d;
   assign w_s[0] = i_s;
   // Stage 0 captures operands, stages 1..LAT-2 retire one dividend bit each, last stage is a plain output register
   for (genvar k = 0; k < LAT; k++) begin : g_st
      localparam bit STEP = (k >= 1) && (k <= LAT - 2);
      logic [63:0]   r_n;
      logic [15:0]   r_r;
      logic [15:0]   r_d;
      logic [SW-1:0] r_s;
      logic [16:0]   w_t;
      logic          w_ge;
      assign w_t  = {w_r[k], w_n[k][63]};
      assign w_ge = w_t >= {1'b0, w_d[k]};
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_n <= '0;
            r_r <= '0;
            r_d <= '0;
            r_s <= '0;
         end else begin
            r_n <= STEP ? {w_n[k][62:0], w_ge} : w_n[k];
            r_r <= !STEP ? w_r[k] : w_ge ? 16'(w_t - {1'b0, w_d[k]}) : w_t[15:0];
            r_d <= w_d[k];
            r_s <= w_s[k];
         end
      end
      assign w_n[k+1] = r_n;
      assign w_r[k+1] = r_r;
      assign w_d[k+1] = r_d;
      assign w_s[k+1] = r_s;
   end
   assign o_res = REM_OUT ? OW'(w_r[LAT]) : OW'(w_n[LAT]);
   assign o_s   = w_s[LAT];
endmodule

module modulation_timer_seg #(
   parameter int LAT = 66
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [63:0] i_time,
   input  logic [14:0] i_cycle,
   input  logic [15:0] i_div,
   output logic [14:0] o_idx
);
   logic [63:0] w_q;
   logic [15:0] w_s1;
   logic [14:0] w_rem;
   logic        w_zero;
   logic [14:0] r_idx;
   // Sideband carries {divisor-was-zero, CYCLE} alongside the quotient
   modulation_timer_div #(.LAT(LAT), .SW(16), .OW(64), .REM_OUT(1'b0)) u_quo (
      .i_clk(i_clk), .i_rst(i_rst), .i_n(i_time), .i_d(i_div),
      .i_s({i_div == 16'd0, i_cycle}), .o_res(w_q), .o_s(w_s1)
   );
   modulation_timer_div #(.LAT(LAT), .SW(1), .OW(15), .REM_OUT(1'b1)) u_mod (
      .i_clk(i_clk), .i_rst(i_rst), .i_n(w_q), .i_d({1'b0, w_s1[14:0]} + 16'd1),
      .i_s(w_s1[15]), .o_res(w_rem), .o_s(w_zero)
   );
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_idx <= '0;
      else       r_idx <= w_zero ? '0 : w_rem;
   end
   assign o_idx = r_idx;
endmodule

module modulation_timer #(
   parameter int DIV_LATENCY = 66
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [63:0] SYS_TIME,
   input  logic [14:0] CYCLE_0,
   input  logic [15:0] FREQ_DIV_0,
   input  logic [14:0] CYCLE_1,
   input  logic [15:0] FREQ_DIV_1,
   output logic [14:0] IDX_0,
   output logic [14:0] IDX_1
);
   modulation_timer_seg #(.LAT(DIV_LATENCY)) u_seg0 (
      .i_clk(CLK), .i_rst(RST), .i_time(SYS_TIME),
      .i_cycle(CYCLE_0), .i_div(FREQ_DIV_0), .o_idx(IDX_0)
   );
`ifdef MODULATION_TIMER_SEGMENT1_EN
   modulation_timer_seg #(.LAT(DIV_LATENCY)) u_seg1 (
      .i_clk(CLK), .i_rst(RST), .i_time(SYS_TIME),
      .i_cycle(CYCLE_1), .i_div(FREQ_DIV_1), .o_idx(IDX_1)
   );
`else
   logic w_unused_seg1;
   assign w_unused_seg1 = ^{CYCLE_1, FREQ_DIV_1};
   assign IDX_1 = '0;
`endif
endmodule

// File: tb/tb_modulation_timer.sv
// tb_modulation_timer: randomized and directed stimulus against an arithmetic reference of the index formula.
module tb_modulation_timer;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [63:0] SYS_TIME = '0;
   logic [14:0] CYCLE_0 = 15'd32767, CYCLE_1 = 15'd999;
   logic [15:0] FREQ_DIV_0 = 16'd8, FREQ_DIV_1 = 16'd24;
   logic [14:0] IDX_0, IDX_1;
   int n_tests = 0, n_fail = 0;
   int cnt = 0, wraps0 = 0, wraps1 = 0;
   logic [14:0] h0 [256];
   logic [14:0] h1 [256];
   logic [14:0] p0 = '0, p1 = '0;

   always #5 CLK = ~CLK;

   modulation_timer dut (
      .CLK(CLK), .RST(RST), .SYS_TIME(SYS_TIME),
      .CYCLE_0(CYCLE_0), .FREQ_DIV_0(FREQ_DIV_0),
      .CYCLE_1(CYCLE_1), .FREQ_DIV_1(FREQ_DIV_1),
      .IDX_0(IDX_0), .IDX_1(IDX_1)
   );

   function automatic logic [14:0] ref_idx(input logic [63:0] s, input logic [15:0] d, input logic [14:0] c);
      logic [63:0] q;
      if (d == 16'd0) return '0;
      q = s / {48'd0, d};
      return 15'(q % ({49'd0, c} + 64'd1));
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // History of expected results indexed by the capture edge number since reset release
   always @(posedge CLK) begin
      if (RST) cnt = 0;
      else begin
         cnt++;
         h0[cnt % 256] = ref_idx(SYS_TIME, FREQ_DIV_0, CYCLE_0);
         h1[cnt % 256] = ref_idx(SYS_TIME, FREQ_DIV_1, CYCLE_1);
      end
   end

   always @(negedge CLK) begin
      logic [14:0] e0, e1;
      e0 = (RST || cnt < 133) ? 15'd0 : h0[(cnt - 132) % 256];
`ifdef MODULATION_TIMER_SEGMENT1_EN
      e1 = (RST || cnt < 133) ? 15'd0 : h1[(cnt - 132) % 256];
`else
      e1 = 15'd0;
`endif
      check("idx0", IDX_0, e0);
      check("idx1", IDX_1, e1);
      if (p0 == 15'd32767 && IDX_0 == 15'd0) wraps0++;
      if (p1 == 15'd999 && IDX_1 == 15'd0) wraps1++;
      p0 = IDX_0;
      p1 = IDX_1;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1 SYS_TIME = SYS_TIME + 64'd1;
      end
   endtask

   function automatic logic [15:0] pick_d();
      int r;
      r = $urandom_range(0, 5);
      return r == 0 ? 16'd0 : r < 3 ? 16'($urandom_range(1, 40)) : 16'($urandom);
   endfunction

   function automatic logic [14:0] pick_c();
      int r;
      r = $urandom_range(0, 3);
      return r == 0 ? 15'd0 : r == 1 ? 15'($urandom_range(1, 20)) : 15'($urandom);
   endfunction

   task automatic rnd_cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
         SYS_TIME   = {$urandom, $urandom};
         FREQ_DIV_0 = pick_d();
         FREQ_DIV_1 = pick_d();
         CYCLE_0    = pick_c();
         CYCLE_1    = pick_c();
      end
   endtask

   initial begin
      #2 RST = 1'b1;
      #1;
      check("rst_idx0", IDX_0, 0);
      check("rst_idx1", IDX_1, 0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      cyc(3000);
      SYS_TIME = 64'd262144 - 64'd2000;
      cyc(4000);
      SYS_TIME   = 64'hFFFF_FFFF_FFFF_FFFF - 64'd999;
      FREQ_DIV_0 = 16'd1;
      CYCLE_0    = 15'd99;
      cyc(1200);
      SYS_TIME   = {$urandom, $urandom};
      FREQ_DIV_0 = 16'd8;
      CYCLE_0    = 15'd32767;
      cyc(400);
      FREQ_DIV_0 = 16'd16;
      cyc(400);
      FREQ_DIV_0 = 16'd0;
      FREQ_DIV_1 = 16'd0;
      cyc(300);
      FREQ_DIV_0 = 16'd1;
      CYCLE_0    = 15'd0;
      FREQ_DIV_1 = 16'd1;
      CYCLE_1    = 15'd32767;
      cyc(300);
      SYS_TIME   = 64'hFFFF_FFFF_FFFF_FF00;
      FREQ_DIV_0 = 16'hFFFF;
      CYCLE_0    = 15'd32767;
      FREQ_DIV_1 = 16'd3;
      CYCLE_1    = 15'd1;
      cyc(300);
      FREQ_DIV_0 = 16'd8;
      FREQ_DIV_1 = 16'd24;
      CYCLE_1    = 15'd999;
      SYS_TIME   = 64'd5000;
      cyc(500);
      @(posedge CLK);
      #3 RST = 1'b1;
      #1;
      check("rst_mid_idx0", IDX_0, 0);
      check("rst_mid_idx1", IDX_1, 0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      cyc(400);
      repeat (30) begin
         SYS_TIME   = {$urandom, $urandom};
         FREQ_DIV_0 = pick_d();
         FREQ_DIV_1 = pick_d();
         CYCLE_0    = pick_c();
         CYCLE_1    = pick_c();
         cyc(150);
      end
      rnd_cyc(3000);
      cyc(140);
      check("wrap0_seen", wraps0 > 0, 1);
`ifdef MODULATION_TIMER_SEGMENT1_EN
      check("wrap1_seen", wraps1 > 0, 1);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
